// File: rtl/serial_port_if.sv
// -----------------------------------------------------------------------------
// serial_port_if
// Parallel-side bus between the memory controller and the serial port.
//
// Signals:
//   data_in      byte to transmit (controller -> port)
//   enable_write one-cycle transmit request (controller -> port)
//   write_ready  transmitter idle, a new byte will be accepted (port -> controller)
//   data_out     head byte of the receive buffer (port -> controller)
//   read_ready   receive buffer non-empty (port -> controller)
//   read_ack     level held high while the CPU reads com data (controller -> port)
//
// Modports:
//   master  memory-controller side
//   slave   serial-port side
// -----------------------------------------------------------------------------
interface serial_port_if;
    logic [7:0] data_in;
    logic       enable_write;
    logic       write_ready;
    logic [7:0] data_out;
    logic       read_ready;
    logic       read_ack;

    modport master (
        output data_in, enable_write, read_ack,
        input  write_ready, data_out, read_ready
    );

    modport slave (
        input  data_in, enable_write, read_ack,
        output write_ready, data_out, read_ready
    );
endinterface

// File: rtl/serial_port.sv
// -----------------------------------------------------------------------------
// serial_port
// 8N1 UART with a one-frame transmitter and a small receive buffer.
//
// Parameters:
//   CLK_FREQ  input clock frequency in Hz
//   BAUD      line rate in bit/s; each bit lasts DIV = round(CLK_FREQ/BAUD) clocks
//
// Ports:
//   clk50M   system clock, all logic on its rising edge
//   rst_n    asynchronous active-low reset
//   bus      serial_port_if.slave parallel bus (see serial_port_if.sv)
//   rxd      asynchronous serial input line
//   txd      registered serial output line, idles high
//
// Build option:
//   SERIAL_RX_FIFO_EN  defined   -> receive buffer is a 4-entry FIFO
//                      undefined -> receive buffer is a single byte register
// -----------------------------------------------------------------------------
module serial_port #(
    parameter int CLK_FREQ = 50000000,
    parameter int BAUD     = 115200
) (
    input  logic          clk50M,
    input  logic          rst_n,
    serial_port_if.slave  bus,
    input  logic          rxd,
    output logic          txd
);

    localparam int DIV  = (CLK_FREQ + BAUD / 2) / BAUD;
    localparam int HALF = DIV / 2;
    localparam int CW   = $clog2(DIV);

    localparam logic [CW-1:0] BIT_LAST  = CW'(DIV - 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(HALF - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_STOP
    } state_e;

    // -------------------------------------------------------------------------
    // Transmitter
    // -------------------------------------------------------------------------
    state_e        tx_state_q, tx_state_d;
    logic [CW-1:0] tx_cnt_q,   tx_cnt_d;
    logic [2:0]    tx_bit_q,   tx_bit_d;
    logic [7:0]    tx_shift_q, tx_shift_d;
    logic          txd_q,      txd_d;

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values of the others, independent of block ordering.
    always_ff @(posedge clk50M or negedge rst_n) begin
        if (!rst_n) begin
            tx_state_q <= ST_IDLE;
            tx_cnt_q   <= '0;
            tx_bit_q   <= '0;
            tx_shift_q <= '0;
            txd_q      <= 1'b1;
        end else begin
            tx_state_q <= tx_state_d;
            tx_cnt_q   <= tx_cnt_d;
            tx_bit_q   <= tx_bit_d;
            tx_shift_q <= tx_shift_d;
            txd_q      <= txd_d;
        end
    end

    // txd_d is the level of the bit that starts at the next edge, so the line
    // changes exactly on bit boundaries without an extra output stage delay.
    always_comb begin
        // NOTE: every signal gets a default before the case so no path leaves
        // one unassigned, which would otherwise infer a latch.
        tx_state_d = tx_state_q;
        tx_cnt_d   = tx_cnt_q + 1'b1;
        tx_bit_d   = tx_bit_q;
        tx_shift_d = tx_shift_q;
        txd_d      = txd_q;

        unique case (tx_state_q)
            ST_IDLE: begin
                tx_cnt_d = '0;
                txd_d    = 1'b1;
                if (bus.enable_write) begin
                    tx_state_d = ST_START;
                    tx_shift_d = bus.data_in;
                    txd_d      = 1'b0;
                end
            end
            ST_START: begin
                if (tx_cnt_q == BIT_LAST) begin
                    tx_cnt_d   = '0;
                    tx_bit_d   = '0;
                    tx_state_d = ST_DATA;
                    txd_d      = tx_shift_q[0];
                end
            end
            ST_DATA: begin
                if (tx_cnt_q == BIT_LAST) begin
                    tx_cnt_d = '0;
                    if (tx_bit_q == 3'd7) begin
                        tx_state_d = ST_STOP;
                        txd_d      = 1'b1;
                    end else begin
                        tx_bit_d   = tx_bit_q + 1'b1;
                        tx_shift_d = {1'b0, tx_shift_q[7:1]};
                        txd_d      = tx_shift_q[1];
                    end
                end
            end
            ST_STOP: begin
                if (tx_cnt_q == BIT_LAST) begin
                    tx_cnt_d   = '0;
                    tx_state_d = ST_IDLE;
                end
            end
            default: tx_state_d = ST_IDLE;
        endcase
    end

    assign txd             = txd_q;
    // Requests arriving outside IDLE are simply not looked at.
    assign bus.write_ready = (tx_state_q == ST_IDLE);

    // -------------------------------------------------------------------------
    // Receiver
    // -------------------------------------------------------------------------
    logic          rxd_meta_q, rxd_sync_q, rxd_prev_q;
    state_e        rx_state_q, rx_state_d;
    logic [CW-1:0] rx_cnt_q,   rx_cnt_d;
    logic [2:0]    rx_bit_q,   rx_bit_d;
    logic [7:0]    rx_shift_q, rx_shift_d;
    logic          push_req;

    // Synchronizer and history reset to the idle line level so release of
    // reset never looks like a start-bit edge.
    always_ff @(posedge clk50M or negedge rst_n) begin
        if (!rst_n) begin
            rxd_meta_q <= 1'b1;
            rxd_sync_q <= 1'b1;
            rxd_prev_q <= 1'b1;
            rx_state_q <= ST_IDLE;
            rx_cnt_q   <= '0;
            rx_bit_q   <= '0;
            rx_shift_q <= '0;
        end else begin
            rxd_meta_q <= rxd;
            rxd_sync_q <= rxd_meta_q;
            rxd_prev_q <= rxd_sync_q;
            rx_state_q <= rx_state_d;
            rx_cnt_q   <= rx_cnt_d;
            rx_bit_q   <= rx_bit_d;
            rx_shift_q <= rx_shift_d;
        end
    end

    always_comb begin
        rx_state_d = rx_state_q;
        rx_cnt_d   = rx_cnt_q + 1'b1;
        rx_bit_d   = rx_bit_q;
        rx_shift_d = rx_shift_q;
        push_req   = 1'b0;

        unique case (rx_state_q)
            ST_IDLE: begin
                rx_cnt_d = '0;
                if (rxd_prev_q && !rxd_sync_q) begin
                    rx_state_d = ST_START;
                end
            end
            ST_START: begin
                // Midpoint check: a line already back high was a glitch.
                if (rx_cnt_q == HALF_LAST) begin
                    rx_cnt_d   = '0;
                    rx_bit_d   = '0;
                    rx_state_d = rxd_sync_q ? ST_IDLE : ST_DATA;
                end
            end
            ST_DATA: begin
                if (rx_cnt_q == BIT_LAST) begin
                    rx_cnt_d   = '0;
                    rx_shift_d = {rxd_sync_q, rx_shift_q[7:1]};
                    if (rx_bit_q == 3'd7) begin
                        rx_state_d = ST_STOP;
                    end else begin
                        rx_bit_d = rx_bit_q + 1'b1;
                    end
                end
            end
            ST_STOP: begin
                if (rx_cnt_q == BIT_LAST) begin
                    rx_cnt_d   = '0;
                    rx_state_d = ST_IDLE;
                    // A low stop bit is a framing error; the byte is dropped.
                    push_req   = rxd_sync_q;
                end
            end
            default: rx_state_d = ST_IDLE;
        endcase
    end

    // -------------------------------------------------------------------------
    // Read acknowledge: one pop per high period of read_ack
    // -------------------------------------------------------------------------
    logic ack_q;
    logic ack_rise;

    always_ff @(posedge clk50M or negedge rst_n) begin
        if (!rst_n) begin
            ack_q <= 1'b0;
        end else begin
            ack_q <= bus.read_ack;
        end
    end

    assign ack_rise = bus.read_ack && !ack_q;

    // -------------------------------------------------------------------------
    // Receive buffer
    // -------------------------------------------------------------------------
    logic do_push;
    logic do_pop;

`ifdef SERIAL_RX_FIFO_EN
    logic [7:0] fifo_q [4];
    logic [1:0] wr_ptr_q;
    logic [1:0] rd_ptr_q;
    logic [2:0] count_q;

    // A pop in the same cycle frees the slot, so a push into a full FIFO
    // survives when both happen together.
    assign do_pop  = ack_rise && (count_q != 3'd0);
    assign do_push = push_req && ((count_q != 3'd4) || do_pop);

    // NOTE: the storage is reset along with the pointers because data_out is
    // a direct view of the head slot and must read 0 during reset.
    always_ff @(posedge clk50M or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 4; i++) begin
                fifo_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                fifo_q[wr_ptr_q] <= rx_shift_q;
                wr_ptr_q         <= wr_ptr_q + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            count_q <= count_q + {2'b00, do_push} - {2'b00, do_pop};
        end
    end

    assign bus.data_out   = fifo_q[rd_ptr_q];
    assign bus.read_ready = (count_q != 3'd0);
`else
    logic [7:0] buf_q;
    logic       full_q;

    assign do_pop  = ack_rise && full_q;
    assign do_push = push_req && (!full_q || do_pop);

    always_ff @(posedge clk50M or negedge rst_n) begin
        if (!rst_n) begin
            buf_q  <= '0;
            full_q <= 1'b0;
        end else if (do_push) begin
            buf_q  <= rx_shift_q;
            full_q <= 1'b1;
        end else if (do_pop) begin
            full_q <= 1'b0;
        end
    end

    assign bus.data_out   = buf_q;
    assign bus.read_ready = full_q;
`endif

endmodule

// File: tb/tb_serial_port.sv
// -----------------------------------------------------------------------------
// tb_serial_port
// Directed bench for serial_port at default parameters (DIV = 434).
// Covers reset values, TX framing/timing, ignored mid-frame requests, RX
// reception with single pop per read_ack, glitch and framing-error rejection,
// receive-buffer overflow (depth depends on SERIAL_RX_FIFO_EN) and reset
// during a TX frame.
// -----------------------------------------------------------------------------
module tb_serial_port;

    localparam int DIV = 434;

    logic clk50M = 1'b0;
    logic rst_n  = 1'b0;
    logic rxd    = 1'b1;
    logic txd;

    serial_port_if bus ();

    serial_port #(
        .CLK_FREQ (50000000),
        .BAUD     (115200)
    ) dut (
        .clk50M (clk50M),
        .rst_n  (rst_n),
        .bus    (bus),
        .rxd    (rxd),
        .txd    (txd)
    );

    always #10 clk50M = ~clk50M;

    int total = 0;
    int bad   = 0;
    int rel   = 0;

    task automatic check(input string tag, input logic [7:0] observed, input logic [7:0] expected);
        total++;
        assert (observed === expected)
        else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge clk50M);
    endtask

    task automatic to_rel(input int target);
        while (rel < target) begin
            @(negedge clk50M);
            rel++;
        end
    endtask

    // Issues one transmit request and checks the frame on txd. rel counts
    // clocks from the accepting edge, which is also where txd goes low.
    task automatic tx_frame(input logic [7:0] b, input bit inject);
        bus.data_in      = b;
        bus.enable_write = 1'b1;
        @(negedge clk50M);
        bus.enable_write = 1'b0;
        bus.data_in      = 8'h00;
        rel = 0;
        check("tx_start_low", 8'(txd), 8'h0);
        check("tx_wr_drop", 8'(bus.write_ready), 8'h0);
        to_rel(DIV - 1);
        check("tx_start_end", 8'(txd), 8'h0);
        to_rel(DIV);
        check("tx_bit0_edge", 8'(txd), 8'(b[0]));
        for (int k = 0; k < 8; k++) begin
            to_rel(DIV * (k + 1) + DIV / 2);
            check($sformatf("tx_bit%0d", k), 8'(txd), 8'(b[k]));
            if (inject && k == 3) begin
                bus.data_in      = 8'h3C;
                bus.enable_write = 1'b1;
                @(negedge clk50M);
                rel++;
                bus.enable_write = 1'b0;
                bus.data_in      = 8'h00;
                check("tx_busy_ignore", 8'(bus.write_ready), 8'h0);
            end
        end
        to_rel(9 * DIV + DIV / 2);
        check("tx_stop", 8'(txd), 8'h1);
        to_rel(10 * DIV - 1);
        check("tx_wr_early", 8'(bus.write_ready), 8'h0);
        to_rel(10 * DIV);
        check("tx_wr_rise", 8'(bus.write_ready), 8'h1);
        to_rel(10 * DIV + 300);
        check("tx_idle_txd", 8'(txd), 8'h1);
        check("tx_idle_wr", 8'(bus.write_ready), 8'h1);
    endtask

    task automatic rx_frame(input logic [7:0] b, input logic stop_bit);
        rxd = 1'b0;
        cycles(DIV);
        for (int i = 0; i < 8; i++) begin
            rxd = b[i];
            cycles(DIV);
        end
        rxd = stop_bit;
        cycles(DIV);
        rxd = 1'b1;
        cycles(20);
    endtask

    task automatic pop(input int hold);
        bus.read_ack = 1'b1;
        cycles(hold);
        bus.read_ack = 1'b0;
        cycles(2);
    endtask

    initial begin
        bus.data_in      = 8'h00;
        bus.enable_write = 1'b0;
        bus.read_ack     = 1'b0;
        rst_n            = 1'b0;
        cycles(3);
        check("rst_txd", 8'(txd), 8'h1);
        check("rst_wr", 8'(bus.write_ready), 8'h1);
        check("rst_rr", 8'(bus.read_ready), 8'h0);
        check("rst_dout", bus.data_out, 8'h00);
        rst_n = 1'b1;
        cycles(3);

        // Transmit 0xA5 with a 0x3C request dropped in mid-frame.
        tx_frame(8'hA5, 1'b1);

        // Receive 0x5A, then one pop for a 5-cycle read_ack.
        rx_frame(8'h5A, 1'b1);
        check("rx_rr", 8'(bus.read_ready), 8'h1);
        check("rx_dout", bus.data_out, 8'h5A);
        bus.read_ack = 1'b1;
        cycles(2);
        check("rx_pop_rr", 8'(bus.read_ready), 8'h0);
        cycles(3);
        bus.read_ack = 1'b0;
        cycles(2);
        check("rx_pop_after", 8'(bus.read_ready), 8'h0);

        // 100-cycle low glitch is rejected at the start-bit midpoint.
        rxd = 1'b0;
        cycles(100);
        rxd = 1'b1;
        cycles(DIV * 11);
        check("rx_glitch", 8'(bus.read_ready), 8'h0);

        // Framing error: stop bit low.
        rx_frame(8'hC3, 1'b0);
        cycles(DIV);
        check("rx_framing", 8'(bus.read_ready), 8'h0);

        // Overflow: five bytes without popping.
        for (int i = 1; i <= 5; i++) begin
            rx_frame(8'(i), 1'b1);
        end
        check("ovf_rr", 8'(bus.read_ready), 8'h1);
`ifdef SERIAL_RX_FIFO_EN
        for (int i = 1; i <= 4; i++) begin
            check($sformatf("fifo_head%0d", i), bus.data_out, 8'(i));
            check($sformatf("fifo_rr%0d", i), 8'(bus.read_ready), 8'h1);
            pop(3);
        end
        check("fifo_empty", 8'(bus.read_ready), 8'h0);
`else
        check("reg_head", bus.data_out, 8'h01);
        pop(3);
        check("reg_empty", 8'(bus.read_ready), 8'h0);
`endif

        // Reset in the middle of TX bit 4 with a byte waiting in the buffer.
        rx_frame(8'h81, 1'b1);
        check("pre_rst_rr", 8'(bus.read_ready), 8'h1);
        check("pre_rst_dout", bus.data_out, 8'h81);
        bus.data_in      = 8'h0F;
        bus.enable_write = 1'b1;
        @(negedge clk50M);
        bus.enable_write = 1'b0;
        cycles(DIV * 5 + 100);
        check("pre_rst_txd", 8'(txd), 8'h0);
        #3 rst_n = 1'b0;
        #1;
        check("mid_rst_txd", 8'(txd), 8'h1);
        check("mid_rst_wr", 8'(bus.write_ready), 8'h1);
        check("mid_rst_rr", 8'(bus.read_ready), 8'h0);
        check("mid_rst_dout", bus.data_out, 8'h00);
        @(negedge clk50M);
        rst_n = 1'b1;
        cycles(DIV * 2);
        check("post_rst_txd", 8'(txd), 8'h1);
        check("post_rst_wr", 8'(bus.write_ready), 8'h1);

        tx_frame(8'hFF, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #3000000;
        $display("FAIL timeout: simulation did not complete, total=%0d bad=%0d", total, bad);
        $fatal(1, "timeout");
    end

endmodule

// File: doc/serial_port.md
SERIAL_PORT -- requirements
Module: serial_port

Interface
REQ-001 Parameter CLK_FREQ, default 50000000, input clock frequency in Hz.
REQ-002 Parameter BAUD, default 115200, line rate in bit/s; DIV = CLK_FREQ/BAUD rounded to nearest integer (434 at defaults).
REQ-003 clk50M  input  1  system clock; all logic on its rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 data_in  input  8  byte to transmit, from the memory controller's com data output.
REQ-006 enable_write  input  1  one-cycle transmit request.
REQ-007 write_ready  output  1  transmitter idle, new byte accepted.
REQ-008 data_out  output  8  head byte of receive buffer.
REQ-009 read_ready  output  1  receive buffer non-empty.
REQ-010 read_ack  input  1  level from memory controller while CPU reads com data; may stay high several cycles.
REQ-011 rxd  input  1  asynchronous serial line in.
REQ-012 txd  output  1  serial line out.

Function
REQ-013 Frame SHALL be 8N1: start bit 0, 8 data bits LSB first, stop bit 1, each bit DIV cycles.
REQ-014 TX states SHALL be IDLE, START, DATA, STOP; IDLE->START on enable_write while write_ready=1, data_in latched that cycle.
REQ-015 write_ready SHALL drop the cycle after acceptance and rise again exactly 10*DIV cycles after txd first goes low.
REQ-016 enable_write while write_ready=0 SHALL be ignored; the in-flight frame is unaffected.
REQ-017 txd SHALL be registered; idle level 1.
REQ-018 rxd SHALL pass a 2-flop synchronizer before any use.
REQ-019 RX states SHALL be IDLE, START, DATA, STOP; IDLE->START on synchronized 1->0 transition.
REQ-020 START SHALL sample at DIV/2 cycles; sample 1 returns to IDLE (glitch rejection), sample 0 enters DATA.
REQ-021 DATA SHALL sample each bit at DIV-cycle intervals from the start midpoint; STOP samples once more.
REQ-022 Stop sample 1 SHALL push the byte into the receive buffer; stop sample 0 (framing error) SHALL discard it; both return to IDLE.
REQ-023 A push while the buffer is full SHALL discard the new byte; stored bytes unchanged.
REQ-024 Pop SHALL occur on the rising edge of read_ack (registered edge detect), exactly one pop per read_ack high period.
REQ-025 Pop on empty buffer SHALL be ignored.
REQ-026 Simultaneous push and pop SHALL both take effect; on a full buffer the pop frees space first so the push is kept.
REQ-027 data_out SHALL always present the head entry; read_ready updates the cycle after push/pop.

Reset
REQ-028 rst_n low SHALL immediately force txd=1, write_ready=1, read_ready=0, data_out=0, both FSMs IDLE, buffer empty, edge-detect history 0.
REQ-029 Reset mid-frame SHALL abort TX and RX; frame bits are not resumed after release.

Configuration
REQ-030 SERIAL_RX_FIFO_EN defined: receive buffer is a 4-entry FIFO with wrap-around read/write pointers.
REQ-031 SERIAL_RX_FIFO_EN undefined: receive buffer is a single byte register; full means read_ready=1.

Verification
REQ-032 enable_write with data_in=8'hA5 -> txd low 434 cycles, then bits 1,0,1,0,0,1,0,1 at 434 cycles each, stop high; write_ready high at cycle 4340.
REQ-033 Second enable_write (8'h3C) mid-frame of 8'hA5 -> ignored; only 8'hA5 appears on txd.
REQ-034 Drive rxd frame 8'h5A at 115200 -> read_ready=1, data_out=8'h5A; read_ack high 5 cycles -> single pop, read_ready=0.
REQ-035 rxd low pulse of 100 cycles -> no byte received; frame with stop bit 0 -> discarded, read_ready stays 0.
REQ-036 With SERIAL_RX_FIFO_EN: receive 8'h01..8'h05 without popping -> 8'h05 dropped; four pops yield 8'h01..8'h04; without macro only 8'h01 retained.
REQ-037 rst_n low at bit 4 of a TX frame -> txd=1, write_ready=1 immediately; after release new 8'hFF transmits cleanly.
